// File: rtl/led_fader_pkg.sv
// led_fader_pkg
// Shared definitions for the LED PWM fader: default sizing constants,
// the per-channel fade state encoding and the fade_rate -> step decode.
package led_fader_pkg;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_FADE_DIV = 39062;

    // Width of the decoded brightness step (largest step is 8).
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } fade_state_t;

    // fade_rate 0..3 selects a brightness step of 1, 2, 4 or 8 per tick.
    function automatic logic [STEP_W-1:0] decode_step(input logic [1:0] rate);
        case (rate)
            2'd0:    decode_step = STEP_W'(1);
            2'd1:    decode_step = STEP_W'(2);
            2'd2:    decode_step = STEP_W'(4);
            default: decode_step = STEP_W'(8);
        endcase
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel
// One LED channel: holds the brightness level, applies the saturating
// fade update on prescaler ticks (or snaps when fading is disabled),
// decodes the fade state and produces the registered PWM drive bit.
//
// Ports:
//   clk_10MHz  in   system clock
//   rst        in   synchronous active-high reset
//   tgt        in   synchronised target level for this LED
//   tick       in   one-cycle fade tick from the shared prescaler
//   fade_en    in   1 = fade on ticks, 0 = snap to target every cycle
//   step       in   decoded brightness step per tick
//   pwm_cnt    in   shared free-running PWM counter
//   bri        out  current brightness level
//   led_pwm    out  registered PWM drive
//   active     out  channel is RISING or FALLING (combinational)
module led_fade_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk_10MHz,
    input  logic                rst,
    input  logic                tgt,
    input  logic                tick,
    input  logic                fade_en,
    input  logic [STEP_W-1:0]   step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] bri,
    output logic                led_pwm,
    output logic                active
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    fade_state_t state;

    // Add with one extra bit; a carry out clamps to full brightness.
    function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] a,
                                                    input logic [STEP_W-1:0]   s);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, a} + (PWM_BITS+1)'(s);
        sat_add = sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0];
    endfunction

    // Subtract with one extra bit; a borrow clamps to zero.
    function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] a,
                                                    input logic [STEP_W-1:0]   s);
        logic [PWM_BITS:0] diff;
        diff = {1'b0, a} - (PWM_BITS+1)'(s);
        sat_sub = diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
    endfunction

    // Brightness register: snap follows the target every cycle, fade
    // only moves on ticks, so a mid-fade target flip just reverses the
    // direction from wherever the level currently is.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            bri <= '0;
        end else if (!fade_en) begin
            bri <= tgt ? MAX : '0;
        end else if (tick) begin
            bri <= tgt ? sat_add(bri, step) : sat_sub(bri, step);
        end
    end

    always_comb begin
        state = OFF;
        if (tgt) begin
            state = (bri == MAX) ? ON : RISING;
        end else begin
            state = (bri == '0) ? OFF : FALLING;
        end
    end

    assign active = (state == RISING) || (state == FALLING);

    // Output stage: full brightness is forced to a steady high rather
    // than the 255/256 duty the plain compare would give.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            led_pwm <= 1'b0;
        end else if (bri == MAX) begin
            led_pwm <= 1'b1;
        end else if (bri == '0) begin
            led_pwm <= 1'b0;
        end else begin
            led_pwm <= (pwm_cnt < bri);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader
// Drives the LED pins from the sequencer pattern with per-LED PWM so
// pattern changes fade in and out. Owns the input synchroniser, the
// shared PWM counter, the fade-tick prescaler, the period sync pulse and
// the busy reduction; each LED is handled by a led_fade_channel.
//
// Ports:
//   clk_10MHz  in   system clock
//   rst        in   synchronous active-high reset
//   led_in     in   target pattern, asynchronous to clk_10MHz
//   fade_en    in   1 = fade, 0 = snap brightness to target
//   fade_rate  in   brightness step per tick: 0->1, 1->2, 2->4, 3->8
//   led_pwm    out  registered PWM drive per LED
//   pwm_sync   out  one-cycle pulse in the cycle after pwm_cnt is 0
//   busy       out  registered: any channel RISING or FALLING
module led_pwm_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int FADE_DIV = DEF_FADE_DIV,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk_10MHz,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                fade_en,
    input  logic [1:0]          fade_rate,
    output logic [NUM_LEDS-1:0] led_pwm,
    output logic                pwm_sync,
    output logic                busy
);

    localparam int              PRE_W    = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [NUM_LEDS-1:0] led_meta;
    logic [NUM_LEDS-1:0] tgt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [STEP_W-1:0]   step;
    logic [NUM_LEDS-1:0] active;

    // Two-flop synchroniser for the pattern coming from the clk_pll domain.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            led_meta <= '0;
            tgt      <= '0;
        end else begin
            led_meta <= led_in;
            tgt      <= led_meta;
        end
    end

    // Shared timebase: PWM counter and fade prescaler.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            presc   <= tick ? '0 : presc + PRE_W'(1);
        end
    end

    assign tick = (presc == PRE_LAST);
    assign step = decode_step(fade_rate);

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk_10MHz(clk_10MHz),
            .rst      (rst),
            .tgt      (tgt[i]),
            .tick     (tick),
            .fade_en  (fade_en),
            .step     (step),
            .pwm_cnt  (pwm_cnt),
            .bri      (),
            .led_pwm  (led_pwm[i]),
            .active   (active[i])
        );
    end

    // Status outputs registered alongside the PWM drive.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            pwm_sync <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pwm_sync <= (pwm_cnt == '0);
            busy     <= |active;
        end
    end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream stage of the multi-pattern LED sequencer. Consumes the sequencer's 8-bit `led_out` pattern and drives the physical LED pins with per-LED PWM, so pattern transitions fade in and out instead of hard-switching. Runs on the 10 MHz board clock. It synchronises the pattern, which is produced in the divided `clk_pll` domain.

## Interface
Parameters:
- `PWM_BITS`, 8: brightness and PWM counter width. The PWM period is 2^PWM_BITS clocks.
- `FADE_DIV`, 39062: clocks per fade tick. At the default, 256 ticks take ≈1 s at 10 MHz. Must be ≥2.
- `NUM_LEDS`, 8: number of channels.

Ports:
- `clk_10MHz`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `led_in`  in  NUM_LEDS: target pattern from the sequencer. Asynchronous to `clk_10MHz`.
- `fade_en`  in  1: 1 = fade; 0 = brightness snaps to the target.
- `fade_rate`  in  2: brightness step per tick. 0→1, 1→2, 2→4, 3→8.
- `led_pwm`  out  NUM_LEDS: PWM drive, registered.
- `pwm_sync`  out  1: one-cycle pulse, registered, high in the cycle after the PWM counter is 0.
- `busy`  out  1: high while any channel is RISING or FALLING.

## Operation
- **Input sync.** `led_in` passes through a 2-flop synchroniser. The result is `tgt[i]`.
- **PWM counter.** `pwm_cnt` (PWM_BITS) free-runs 0..2^PWM_BITS−1 and wraps to 0.
- **Prescaler.** Counts 0..FADE_DIV−1. `tick` is high for one cycle when the count equals FADE_DIV−1, then the count wraps to 0.
- **Per-channel brightness.** `bri[i]` is PWM_BITS wide. Let MAX = 2^PWM_BITS−1 and `step` = the decoded `fade_rate`.
  - `fade_en`=0: every cycle, `bri` ← `tgt`? MAX : 0.
  - `fade_en`=1, on `tick` only:
    - `tgt`=1: `bri` ← min(`bri`+`step`, MAX).
    - `tgt`=0: `bri` ← max(`bri`−`step`, 0).
  - Both operations use a saturating add/subtract with a one-bit-wider intermediate. There is no wrap-around.
  - `bri` is unchanged on non-tick cycles.
- **Per-channel state.** Decoded combinationally from `bri` and `tgt`:
  - OFF (`bri`=0, `tgt`=0).
  - RISING (`tgt`=1, `bri`<MAX).
  - ON (`bri`=MAX, `tgt`=1).
  - FALLING (`tgt`=0, `bri`>0).
  - Transitions: OFF→RISING on `tgt` rise. RISING→ON at saturation. ON→FALLING on `tgt` fall. FALLING→OFF at 0.
  - RISING↔FALLING reverses immediately when `tgt` toggles mid-fade. The fade continues from the current `bri`, with no jump.
- **Output.** `led_pwm[i]` is registered:
  - 1 if `bri`=MAX.
  - 0 if `bri`=0.
  - otherwise (`pwm_cnt` < `bri`).
  - Duty is `bri`/2^PWM_BITS, except MAX, which is forced to 100 %.
- **`busy`.** Registered OR over all channels of (RISING or FALLING).
- **`fade_rate` changes.** Take effect on the next tick.

## Timing
- **Reset** (`rst`=1 at a clock edge). Next cycle:
  - `pwm_cnt`=0, prescaler=0, synchroniser flops=0, all `bri`=0.
  - `led_pwm`=0, `pwm_sync`=0, `busy`=0.
- **Reset mid-fade.** All brightness clears to 0 immediately. There is no fade-out.
- **`led_in` → `tgt`.** 2 cycles.
- **`tgt` → `bri` change.** Fade mode: the first `tick` at or after `tgt` changes. Snap mode: 1 cycle.
- **`bri` → `led_pwm`.** 1 cycle.
- **Snap-mode total latency.** `led_in` edge to `led_pwm` steady level at MAX or 0 is 4 cycles.
- **Full fade duration** at `step`=1: MAX ticks = MAX·FADE_DIV clocks.
- **Simultaneous `tgt` toggle and `tick`.** The tick uses the new `tgt`.
- **`fade_en` toggled 1→0 mid-fade.** Snaps on the next cycle.
- **`fade_en` toggled 0→1.** Fading resumes from MAX or 0.

## Structure
- **Package `led_fader_pkg`:**
  - default `PWM_BITS` / `FADE_DIV` constants.
  - `fade_state_t` enum {OFF, RISING, ON, FALLING}.
  - step decode function (`fade_rate` → 1/2/4/8).
- **Sub-module `led_fade_channel`:** one instance per LED. It holds `bri`, the saturating update, the state decode and the output compare. It receives `tgt`, `tick`, `step`, `fade_en` and `pwm_cnt`.
- **Top level:** owns the synchroniser, `pwm_cnt`, the prescaler, `pwm_sync` and the `busy` reduction.

## Test plan
Benches use FADE_DIV=4 and PWM_BITS=8.
1. **Reset.** Hold `rst` 3 cycles with `led_in`=8'hFF → `led_pwm`=0, `busy`=0, every `bri`=0. Release → `pwm_sync` pulses every 256 cycles.
2. **Snap mode.** `fade_en`=0, `led_in` 8'h00→8'hA5 → exactly 4 cycles later `led_pwm`=8'hA5, constant across a full PWM period.
3. **Fade-in at `fade_rate`=3.** `led_in[0]` 0→1 → `bri[0]` steps 8,16,…,248,255 on consecutive ticks; it saturates at 255 after 32 ticks, not 256 or 0. `busy` falls 1 cycle after saturation. Duty at `bri`=128 measures 128/256.
4. **Mid-fade reversal.** `fade_rate`=0; set `led_in[3]`=1 until `bri[3]`=100, then 0 → the next tick gives 99, with no jump. It reaches 0 after 100 ticks, and `led_pwm[3]` stays 0 thereafter.
5. **Reset mid-fade.** With `bri`≈50 on all channels, assert `rst` for 1 cycle → the next cycle has all `bri`=0 and `led_pwm`=0. Fading restarts from 0 after release.
6. **Rate change.** Change `fade_rate` 0→2 between ticks during a rise from `bri`=10 → the next tick gives 14.
